// File: rtl/reg_file_dumper.sv
// Debug readout engine: sweeps the register file read port from START_REG to
// NUM_REGS-1, streams each value out on valid/ready and keeps an XOR checksum.
module reg_file_dumper #(
  parameter int NUM_REGS  = 32,
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 64,
  parameter int START_REG = 0
) (
  input  logic              CLK,
  input  logic              reset,
  input  logic              dump_start,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [ADDR_W-1:0] out_index,
  output logic              out_last,
  output logic              busy,
  output logic              wb_stall,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_SEND,
    S_DONE
  } state_t;

  localparam logic              EMPTY = (START_REG > NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] FIRST = ADDR_W'(START_REG);
  localparam logic [ADDR_W-1:0] LAST  = ADDR_W'(NUM_REGS - 1);

  state_t              state_q;
  logic [ADDR_W-1:0]   rd_addr_q;
  logic                out_valid_q;
  logic [DATA_W-1:0]   out_data_q;
  logic [ADDR_W-1:0]   out_index_q;
  logic                out_last_q;
  logic                busy_q;
  logic                done_q;
  logic [DATA_W-1:0]   checksum_q;

  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q     <= S_IDLE;
      rd_addr_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_index_q <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      checksum_q  <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (dump_start) begin
            checksum_q <= '0;
            busy_q     <= 1'b1;
            // An out-of-range first register yields an empty dump.
            if (EMPTY) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rd_addr_q <= FIRST;
              state_q   <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          out_data_q  <= rd_data;
          out_index_q <= rd_addr_q;
          out_last_q  <= (rd_addr_q == LAST);
          out_valid_q <= 1'b1;
          state_q     <= S_SEND;
        end
        S_SEND: begin
          if (out_ready) begin
            checksum_q  <= checksum_q ^ out_data_q;
            out_valid_q <= 1'b0;
            if (out_last_q) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rd_addr_q <= rd_addr_q + 1'b1;
              state_q   <= S_LOAD;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign rd_addr   = rd_addr_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_index = out_index_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;
  assign wb_stall  = busy_q;
  assign done      = done_q;
  assign checksum  = checksum_q;

endmodule

// File: tb/tb_reg_file_dumper.sv
// Self-checking bench for reg_file_dumper: two instances (START_REG 0 and 1)
// read a shared behavioural register file; expectations come from an array model.
module tb_reg_file_dumper;

  logic        CLK = 1'b0;
  logic        reset;
  logic        dump_start [2];
  logic        out_ready  [2];
  logic [4:0]  rd_addr    [2];
  logic [63:0] rd_data    [2];
  logic        out_valid  [2];
  logic [63:0] out_data   [2];
  logic [4:0]  out_index  [2];
  logic        out_last   [2];
  logic        busy       [2];
  logic        wb_stall   [2];
  logic        done       [2];
  logic [63:0] checksum   [2];

  logic [63:0] regs [32];

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  assign rd_data[0] = regs[rd_addr[0]];
  assign rd_data[1] = regs[rd_addr[1]];

  reg_file_dumper #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(64), .START_REG(0)) dut0 (
    .CLK(CLK), .reset(reset), .dump_start(dump_start[0]), .rd_addr(rd_addr[0]),
    .rd_data(rd_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .out_data(out_data[0]), .out_index(out_index[0]), .out_last(out_last[0]),
    .busy(busy[0]), .wb_stall(wb_stall[0]), .done(done[0]), .checksum(checksum[0])
  );

  reg_file_dumper #(.NUM_REGS(32), .ADDR_W(5), .DATA_W(64), .START_REG(1)) dut1 (
    .CLK(CLK), .reset(reset), .dump_start(dump_start[1]), .rd_addr(rd_addr[1]),
    .rd_data(rd_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .out_data(out_data[1]), .out_index(out_index[1]), .out_last(out_last[1]),
    .busy(busy[1]), .wb_stall(wb_stall[1]), .done(done[1]), .checksum(checksum[1])
  );

  // One full dump on instance sel. Returns on the falling edge of the cycle after
  // done (or after a reset abort when abort_idx matches a beat index).
  task automatic run_dump(input int sel, input bit rand_ready, input bit extra_starts,
                          input int abort_idx);
    int first, n, beats, stalls, t, idx;
    bit got_done, prev_stall, rdy;
    logic [63:0] exp_ck, prev_data;
    logic [4:0] prev_idx;
    first = (sel == 0) ? 0 : 1;
    n = 32 - first;
    exp_ck = '0; beats = 0; stalls = 0; t = 0;
    got_done = 0; prev_stall = 0; prev_data = '0; prev_idx = '0;
    dump_start[sel] = 1'b1;
    out_ready[sel] = 1'b1;
    @(posedge CLK);
    while (!got_done && t < 400) begin
      @(negedge CLK);
      dump_start[sel] = 1'b0;
      checks++;
      if (busy[sel] !== 1'b1 || wb_stall[sel] !== 1'b1) begin
        errors++;
        $display("FAIL busy_active t=%0d: busy=%b wb_stall=%b expected 1/1", t, busy[sel], wb_stall[sel]);
      end
      if (t == 0) begin
        checks++;
        if (checksum[sel] !== 64'h0) begin
          errors++;
          $display("FAIL checksum_cleared: got %h expected 0", checksum[sel]);
        end
      end
      if (done[sel] === 1'b1) begin
        got_done = 1;
        checks++;
        if (t != 2 * n + stalls || beats != n) begin
          errors++;
          $display("FAIL done_timing: t=%0d beats=%0d expected t=%0d beats=%0d", t, beats, 2 * n + stalls, n);
        end
        checks++;
        if (checksum[sel] !== exp_ck) begin
          errors++;
          $display("FAIL checksum_done: got %h expected %h", checksum[sel], exp_ck);
        end
      end else if (prev_stall) begin
        checks++;
        if (out_valid[sel] !== 1'b1 || out_data[sel] !== prev_data || out_index[sel] !== prev_idx) begin
          errors++;
          $display("FAIL stall_stable: valid=%b data=%h idx=%0d expected 1 %h %0d",
                   out_valid[sel], out_data[sel], out_index[sel], prev_data, prev_idx);
        end
      end
      rdy = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      prev_stall = 0;
      if (out_valid[sel] === 1'b1 && !got_done) begin
        idx = first + beats;
        checks++;
        if (out_data[sel] !== regs[idx] || out_index[sel] !== 5'(idx) || out_last[sel] !== (idx == 31)) begin
          errors++;
          $display("FAIL beat%0d: data=%h idx=%0d last=%b expected %h %0d %b",
                   beats, out_data[sel], out_index[sel], out_last[sel], regs[idx], idx, idx == 31);
        end
        if (sel == 1) begin
          checks++;
          if (out_data[sel] === 64'hDEAD) begin
            errors++;
            $display("FAIL skip_x0: got %h expected not DEAD", out_data[sel]);
          end
        end
        if (idx == abort_idx) begin
          reset = 1'b1;
          @(posedge CLK);
          @(negedge CLK);
          reset = 1'b0;
          checks++;
          if (out_valid[sel] !== 1'b0 || busy[sel] !== 1'b0 || checksum[sel] !== 64'h0 || done[sel] !== 1'b0) begin
            errors++;
            $display("FAIL abort: valid=%b busy=%b ck=%h done=%b expected 0 0 0 0",
                     out_valid[sel], busy[sel], checksum[sel], done[sel]);
          end
          for (int c = 0; c < 4; c++) begin
            @(negedge CLK);
            checks++;
            if (done[sel] !== 1'b0 || busy[sel] !== 1'b0) begin
              errors++;
              $display("FAIL abort_quiet: done=%b busy=%b expected 0 0", done[sel], busy[sel]);
            end
          end
          return;
        end
        if (rdy) begin
          exp_ck ^= regs[idx];
          beats++;
          if (extra_starts && (beats == 4 || beats == 21)) dump_start[sel] = 1'b1;
        end else begin
          stalls++;
          prev_stall = 1;
          prev_data = out_data[sel];
          prev_idx = out_index[sel];
        end
      end
      out_ready[sel] = rdy;
      @(posedge CLK);
      t++;
    end
    @(negedge CLK);
    checks++;
    if (!got_done) begin
      errors++;
      $display("FAIL done_timeout: got no done expected done within budget");
    end
    checks++;
    if (busy[sel] !== 1'b0 || done[sel] !== 1'b0 || checksum[sel] !== exp_ck) begin
      errors++;
      $display("FAIL post_done: busy=%b done=%b ck=%h expected 0 0 %h", busy[sel], done[sel], checksum[sel], exp_ck);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      dump_start[s] = 1'b0;
      out_ready[s] = 1'b1;
    end
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (rd_addr[s] !== 5'd0 || out_valid[s] !== 1'b0 || out_data[s] !== 64'h0 || out_index[s] !== 5'd0 ||
          out_last[s] !== 1'b0 || busy[s] !== 1'b0 || wb_stall[s] !== 1'b0 || done[s] !== 1'b0 ||
          checksum[s] !== 64'h0) begin
        errors++;
        $display("FAIL reset_values dut%0d: addr=%0d v=%b d=%h i=%0d l=%b b=%b w=%b dn=%b ck=%h expected all 0",
                 s, rd_addr[s], out_valid[s], out_data[s], out_index[s], out_last[s], busy[s],
                 wb_stall[s], done[s], checksum[s]);
      end
    end
    reset = 1'b0;
  endtask

  task automatic test_full_dump();
    run_dump(0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random_ready();
    run_dump(0, 1'b1, 1'b0, -1);
  endtask

  task automatic test_ignored_start();
    run_dump(0, 1'b0, 1'b1, -1);
  endtask

  task automatic test_reset_mid_dump();
    run_dump(0, 1'b0, 1'b0, 10);
    run_dump(0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_start_reg1();
    regs[0] = 64'hDEAD;
    run_dump(1, 1'b0, 1'b0, -1);
    run_dump(1, 1'b1, 1'b0, -1);
    regs[0] = 64'h0;
  endtask

  task automatic test_back_to_back();
    run_dump(0, 1'b0, 1'b0, -1);
    run_dump(0, 1'b0, 1'b0, -1);
  endtask

  task automatic test_random_regs();
    for (int i = 0; i < 32; i++) regs[i] = {$urandom, $urandom};
    run_dump(0, 1'b1, 1'b0, -1);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) regs[i] = 64'h0101_0101_0101_0101 * 64'(i);
    test_reset();
    test_full_dump();
    test_random_ready();
    test_ignored_start();
    test_reset_mid_dump();
    test_start_reg1();
    test_back_to_back();
    test_random_regs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
